control_bp: RTL and testbench

- Next-generation pipelined control unit for the 3-stage (Decode/Execute/Writeback) RV32I core.
- Adds a parametrised dynamic branch predictor (table of saturating counters indexed by PC) in place of the static branched_flag scheme.
- Adds unsigned branches (BLTU/BGEU), explicit misprediction resolution in Execute, and a legal-NOP decode for unsupported opcodes (no X outputs).
- Sits beside the datapath; the datapath consumes predict_taken_F in Fetch and PCSrcE in Execute.

---
 rtl/control_bp_pkg.sv | 74 +++++++
 rtl/control_bp_if.sv | 35 +++
 rtl/control_bp_bht_sat_ctr.sv | 47 ++++
 rtl/control_bp.sv | 193 +++++++++++++++++++
 tb/tb_control_bp.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/control_bp_pkg.sv
// Shared types and constants for the pipelined control unit with a dynamic branch predictor.
package control_bp_pkg;

    localparam int BHT_ENTRIES_DFLT = 16;
    localparam int CTR_BITS_DFLT    = 2;
    localparam int IDX_W_DFLT       = $clog2(BHT_ENTRIES_DFLT);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RALU   = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0110,
        ALU_PASSB = 4'b0111
    } alu_func_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } imm_fmt_t;

    typedef enum logic [1:0] {
        PC_SEQ      = 2'b00,
        PC_TARGET   = 2'b01,
        PC_FALLTHRU = 2'b10
    } pcsrc_t;

    typedef enum logic [1:0] {
        EXP_ALU   = 2'b00,
        EXP_LINK  = 2'b01,
        EXP_UPPER = 2'b10,
        EXP_MEM   = 2'b11
    } expath_t;

    typedef struct packed {
        logic      RegWE_E;
        logic      RegWE_W;
        logic      OpBSrc;
        logic      MemWrite;
        expath_t   ExPath;
        alu_func_t ALUFunc;
        logic      branch;
        logic      jump;
    } ctrl_bundle_t;

    localparam ctrl_bundle_t CTRL_BUBBLE = '0;

    // Shifts have no ALU encoding here, so they fall back to ADD.
    function automatic alu_func_t alu_from_funct3(input logic [2:0] funct3, input logic sub);
        case (funct3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/control_bp_if.sv
// Control-unit bundle: hazard/datapath side is master, control_bp is slave.
interface control_bp_if #(parameter int XLEN = 32);
    logic            StallD, StallE, StallW;
    logic            FlushD, FlushE, FlushW;
    logic [6:0]      op_F;
    logic [2:0]      funct3_F;
    logic            funct7b5_F;
    logic [XLEN-1:0] pc_F;
    logic            Z, N, C;
    logic            predict_taken_F;
    logic [2:0]      ImmFormatD;
    logic            illegal_D;
    logic            RegWE_E_E, RegWE_W_E, OpBSrcE, branch_E, jump_E;
    logic [1:0]      ExPathE;
    logic [3:0]      ALUFuncE;
    logic [1:0]      PCSrcE;
    logic            mispredict_E;
    logic            RegWE_E_W, RegWE_W_W, MemWriteW;

    modport master (
        output StallD, StallE, StallW, FlushD, FlushE, FlushW,
        output op_F, funct3_F, funct7b5_F, pc_F, Z, N, C,
        input  predict_taken_F, ImmFormatD, illegal_D,
        input  RegWE_E_E, RegWE_W_E, OpBSrcE, branch_E, jump_E, ExPathE, ALUFuncE,
        input  PCSrcE, mispredict_E, RegWE_E_W, RegWE_W_W, MemWriteW
    );

    modport slave (
        input  StallD, StallE, StallW, FlushD, FlushE, FlushW,
        input  op_F, funct3_F, funct7b5_F, pc_F, Z, N, C,
        output predict_taken_F, ImmFormatD, illegal_D,
        output RegWE_E_E, RegWE_W_E, OpBSrcE, branch_E, jump_E, ExPathE, ALUFuncE,
        output PCSrcE, mispredict_E, RegWE_E_W, RegWE_W_W, MemWriteW
    );
endinterface

// File: rtl/control_bp_bht_sat_ctr.sv
// Branch history table of saturating counters: combinational lookup, clocked update.
module bht_sat_ctr #(
    parameter int ENTRIES  = 16,
    parameter int CTR_BITS = 2,
    parameter int IDX_W    = $clog2(ENTRIES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_W-1:0]    rd_idx,
    output logic [CTR_BITS-1:0] rd_ctr,
    input  logic                upd_en,
    input  logic [IDX_W-1:0]    upd_idx,
    input  logic                upd_taken
);
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

    logic [CTR_BITS-1:0] ctr_q [ENTRIES];

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            logic [CTR_BITS-1:0] ctr_reg, ctr_next;

            always_comb begin
                ctr_next = ctr_reg;
                if (upd_en && upd_idx == IDX_W'(gi)) begin
                    if (upd_taken) begin
                        if (ctr_reg != CTR_MAX) ctr_next = ctr_reg + 1'b1;
                    end else if (ctr_reg != '0) begin
                        ctr_next = ctr_reg - 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) ctr_reg <= CTR_INIT;
                else        ctr_reg <= ctr_next;
            end

            assign ctr_q[gi] = ctr_reg;
        end
    endgenerate

    // Lookup sees the stored value only; an update landing this edge is not bypassed.
    assign rd_ctr = ctr_q[rd_idx];
endmodule

// File: rtl/control_bp.sv
// Decode/Execute/Writeback control with a PC-indexed dynamic branch predictor.
module control_bp
    import control_bp_pkg::*;
#(
    parameter int BHT_ENTRIES = BHT_ENTRIES_DFLT,
    parameter int CTR_BITS    = CTR_BITS_DFLT,
    parameter int PC_IDX_LSB  = 2,
    parameter int XLEN        = 32
) (
    input logic         clk,
    input logic         reset,
    control_bp_if.slave bus
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [XLEN-1:0]     pc_f;
    logic                unused_pc_bits;
    logic [IDX_W-1:0]    idx_f;
    logic [CTR_BITS-1:0] ctr_f;
    logic                predict_f;

    assign pc_f           = bus.pc_F;
    assign unused_pc_bits = ^pc_f;
    assign idx_f          = pc_f[PC_IDX_LSB +: IDX_W];
    assign predict_f      = (bus.op_F == OP_JAL) | ((bus.op_F == OP_BRANCH) & ctr_f[CTR_BITS-1]);
    assign bus.predict_taken_F = predict_f;

    // F -> D
    logic             valid_d_reg, f7b5_d_reg, pred_d_reg;
    logic [6:0]       op_d_reg;
    logic [2:0]       funct3_d_reg;
    logic [IDX_W-1:0] idx_d_reg;

    always_ff @(posedge clk) begin
        if (!reset || bus.FlushD) begin
            valid_d_reg  <= 1'b0;
            op_d_reg     <= '0;
            funct3_d_reg <= '0;
            f7b5_d_reg   <= 1'b0;
            pred_d_reg   <= 1'b0;
            idx_d_reg    <= '0;
        end else if (!bus.StallD) begin
            valid_d_reg  <= 1'b1;
            op_d_reg     <= bus.op_F;
            funct3_d_reg <= bus.funct3_F;
            f7b5_d_reg   <= bus.funct7b5_F;
            pred_d_reg   <= predict_f;
            idx_d_reg    <= idx_f;
        end
    end

    ctrl_bundle_t ctrl_d;
    imm_fmt_t     imm_d;
    logic         legal_d;

    always_comb begin
        ctrl_d  = CTRL_BUBBLE;
        imm_d   = IMM_I;
        legal_d = 1'b1;
        case (op_d_reg)
            OP_IALU: begin
                ctrl_d.RegWE_E = 1'b1;
                ctrl_d.OpBSrc  = 1'b1;
                ctrl_d.ALUFunc = alu_from_funct3(funct3_d_reg, 1'b0);
            end
            OP_RALU: begin
                ctrl_d.RegWE_E = 1'b1;
                ctrl_d.ALUFunc = alu_from_funct3(funct3_d_reg, f7b5_d_reg);
            end
            OP_LOAD: begin
                ctrl_d.RegWE_W = 1'b1;
                ctrl_d.OpBSrc  = 1'b1;
                ctrl_d.ExPath  = EXP_MEM;
            end
            OP_STORE: begin
                ctrl_d.MemWrite = 1'b1;
                ctrl_d.OpBSrc   = 1'b1;
                ctrl_d.ExPath   = EXP_MEM;
                imm_d           = IMM_S;
            end
            OP_BRANCH: begin
                ctrl_d.branch  = 1'b1;
                ctrl_d.ALUFunc = ALU_SUB;
                imm_d          = IMM_B;
            end
            OP_JAL: begin
                ctrl_d.RegWE_E = 1'b1;
                ctrl_d.jump    = 1'b1;
                ctrl_d.ExPath  = EXP_LINK;
                imm_d          = IMM_J;
            end
            OP_LUI: begin
                ctrl_d.RegWE_E = 1'b1;
                ctrl_d.OpBSrc  = 1'b1;
                ctrl_d.ExPath  = EXP_UPPER;
                ctrl_d.ALUFunc = ALU_PASSB;
                imm_d          = IMM_U;
            end
            default: legal_d = 1'b0;
        endcase
    end

    assign bus.ImmFormatD = imm_d;
    assign bus.illegal_D  = valid_d_reg & ~legal_d;

    // D -> E
    ctrl_bundle_t     ctrl_e_reg;
    logic [2:0]       funct3_e_reg;
    logic             pred_e_reg;
    logic [IDX_W-1:0] idx_e_reg;

    always_ff @(posedge clk) begin
        if (!reset || bus.FlushE) begin
            ctrl_e_reg   <= CTRL_BUBBLE;
            funct3_e_reg <= '0;
            pred_e_reg   <= 1'b0;
            idx_e_reg    <= '0;
        end else if (!bus.StallE) begin
            ctrl_e_reg   <= ctrl_d;
            funct3_e_reg <= funct3_d_reg;
            pred_e_reg   <= pred_d_reg;
            idx_e_reg    <= idx_d_reg;
        end
    end

    logic   taken_e, br_legal_e, upd_en;
    pcsrc_t pcsrc_e;

    always_comb begin
        taken_e    = 1'b0;
        br_legal_e = 1'b1;
        case (funct3_e_reg)
            3'b000:  taken_e = bus.Z;
            3'b001:  taken_e = ~bus.Z;
            3'b100:  taken_e = bus.N;
            3'b101:  taken_e = ~bus.N;
            3'b110:  taken_e = bus.C;
            3'b111:  taken_e = ~bus.C;
            default: br_legal_e = 1'b0;
        endcase
        pcsrc_e = PC_SEQ;
        if (ctrl_e_reg.branch) begin
            if (taken_e && !pred_e_reg)      pcsrc_e = PC_TARGET;
            else if (!taken_e && pred_e_reg) pcsrc_e = PC_FALLTHRU;
        end
    end

    // A stalled branch resolves again next cycle, so it must not train the table twice.
    assign upd_en = ctrl_e_reg.branch & ~bus.StallE & br_legal_e;

    bht_sat_ctr #(
        .ENTRIES  (BHT_ENTRIES),
        .CTR_BITS (CTR_BITS),
        .IDX_W    (IDX_W)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (idx_f),
        .rd_ctr    (ctr_f),
        .upd_en    (upd_en),
        .upd_idx   (idx_e_reg),
        .upd_taken (taken_e)
    );

    assign bus.RegWE_E_E    = ctrl_e_reg.RegWE_E;
    assign bus.RegWE_W_E    = ctrl_e_reg.RegWE_W;
    assign bus.OpBSrcE      = ctrl_e_reg.OpBSrc;
    assign bus.branch_E     = ctrl_e_reg.branch;
    assign bus.jump_E       = ctrl_e_reg.jump;
    assign bus.ExPathE      = ctrl_e_reg.ExPath;
    assign bus.ALUFuncE     = ctrl_e_reg.ALUFunc;
    assign bus.PCSrcE       = pcsrc_e;
    assign bus.mispredict_E = (pcsrc_e != PC_SEQ);

    // E -> W
    logic rwe_e_w_reg, rwe_w_w_reg, mem_write_w_reg;

    always_ff @(posedge clk) begin
        if (!reset || bus.FlushW) begin
            rwe_e_w_reg     <= 1'b0;
            rwe_w_w_reg     <= 1'b0;
            mem_write_w_reg <= 1'b0;
        end else if (!bus.StallW) begin
            rwe_e_w_reg     <= ctrl_e_reg.RegWE_E;
            rwe_w_w_reg     <= ctrl_e_reg.RegWE_W;
            mem_write_w_reg <= ctrl_e_reg.MemWrite;
        end
    end

    assign bus.RegWE_E_W = rwe_e_w_reg;
    assign bus.RegWE_W_W = rwe_w_w_reg;
    assign bus.MemWriteW = mem_write_w_reg;
endmodule

// File: tb/tb_control_bp.sv
// Directed bench for control_bp: decode table plus predictor training, aliasing, stall and flush sequences.
module tb_control_bp;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    control_bp_if #(.XLEN(32)) bp_if();

    control_bp #(
        .BHT_ENTRIES (16),
        .CTR_BITS    (2),
        .PC_IDX_LSB  (2),
        .XLEN        (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bp_if)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] pc;
        logic [2:0]  znc;    // {Z,N,C} while the instruction is in Execute
        logic        pred;
        logic [2:0]  imm;
        logic        ill;
        logic [4:0]  ctl;    // {RegWE_E, RegWE_W, OpBSrc, branch, jump}
        logic [1:0]  path;
        logic [3:0]  alu;
        logic [1:0]  pcsrc;
        logic        mw;
    } vec_t;

    vec_t vecs[20];

    logic       cap_pred, cap_ill, cap_misp;
    logic [2:0] cap_imm, cap_w;
    logic [4:0] cap_ctl;
    logic [1:0] cap_path, cap_pcsrc;
    logic [3:0] cap_alu;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_f(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [31:0] pc);
        bp_if.op_F       = op;
        bp_if.funct3_F   = f3;
        bp_if.funct7b5_F = f7;
        bp_if.pc_F       = pc;
    endtask

    // Issue one instruction followed by ADDI fillers; capture it in F, D, E and W.
    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [31:0] pc, input logic [2:0] znc);
        set_f(op, f3, f7, pc);
        #1;
        cap_pred = bp_if.predict_taken_F;
        tick();
        cap_imm = bp_if.ImmFormatD;
        cap_ill = bp_if.illegal_D;
        set_f(7'h13, 3'b000, 1'b0, 32'h0);
        tick();
        {bp_if.Z, bp_if.N, bp_if.C} = znc;
        #1;
        cap_ctl   = {bp_if.RegWE_E_E, bp_if.RegWE_W_E, bp_if.OpBSrcE, bp_if.branch_E, bp_if.jump_E};
        cap_path  = bp_if.ExPathE;
        cap_alu   = bp_if.ALUFuncE;
        cap_pcsrc = bp_if.PCSrcE;
        cap_misp  = bp_if.mispredict_E;
        tick();
        cap_w = {bp_if.RegWE_E_W, bp_if.RegWE_W_W, bp_if.MemWriteW};
        {bp_if.Z, bp_if.N, bp_if.C} = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //            op     f3      f7    pc      znc    pred imm     ill  ctl       path   alu      pcsrc  mw
        vecs[0]  = '{7'h13, 3'b000, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10100, 2'b00, 4'b0000, 2'b00, 1'b0};
        vecs[1]  = '{7'h33, 3'b000, 1'b1, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10000, 2'b00, 4'b0001, 2'b00, 1'b0};
        vecs[2]  = '{7'h33, 3'b011, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10000, 2'b00, 4'b0110, 2'b00, 1'b0};
        vecs[3]  = '{7'h13, 3'b100, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10100, 2'b00, 4'b0100, 2'b00, 1'b0};
        vecs[4]  = '{7'h13, 3'b110, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10100, 2'b00, 4'b0011, 2'b00, 1'b0};
        vecs[5]  = '{7'h13, 3'b111, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10100, 2'b00, 4'b0010, 2'b00, 1'b0};
        vecs[6]  = '{7'h13, 3'b010, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10100, 2'b00, 4'b0101, 2'b00, 1'b0};
        vecs[7]  = '{7'h37, 3'b000, 1'b0, 32'h00, 3'b000, 1'b0, 3'b100, 1'b0, 5'b10100, 2'b10, 4'b0111, 2'b00, 1'b0};
        vecs[8]  = '{7'h03, 3'b010, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b01100, 2'b11, 4'b0000, 2'b00, 1'b0};
        vecs[9]  = '{7'h23, 3'b010, 1'b0, 32'h00, 3'b000, 1'b0, 3'b001, 1'b0, 5'b00100, 2'b11, 4'b0000, 2'b00, 1'b1};
        vecs[10] = '{7'h6F, 3'b000, 1'b0, 32'h30, 3'b000, 1'b1, 3'b011, 1'b0, 5'b10001, 2'b01, 4'b0000, 2'b00, 1'b0};
        vecs[11] = '{7'h63, 3'b110, 1'b0, 32'h14, 3'b001, 1'b0, 3'b010, 1'b0, 5'b00010, 2'b00, 4'b0001, 2'b01, 1'b0};
        vecs[12] = '{7'h63, 3'b111, 1'b0, 32'h18, 3'b001, 1'b0, 3'b010, 1'b0, 5'b00010, 2'b00, 4'b0001, 2'b00, 1'b0};
        vecs[13] = '{7'h63, 3'b101, 1'b0, 32'h1C, 3'b000, 1'b0, 3'b010, 1'b0, 5'b00010, 2'b00, 4'b0001, 2'b01, 1'b0};
        vecs[14] = '{7'h63, 3'b100, 1'b0, 32'h1C, 3'b010, 1'b1, 3'b010, 1'b0, 5'b00010, 2'b00, 4'b0001, 2'b00, 1'b0};
        vecs[15] = '{7'h63, 3'b010, 1'b0, 32'h20, 3'b100, 1'b0, 3'b010, 1'b0, 5'b00010, 2'b00, 4'b0001, 2'b00, 1'b0};
        vecs[16] = '{7'h63, 3'b010, 1'b0, 32'h20, 3'b100, 1'b0, 3'b010, 1'b0, 5'b00010, 2'b00, 4'b0001, 2'b00, 1'b0};
        vecs[17] = '{7'h73, 3'b000, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b1, 5'b00000, 2'b00, 4'b0000, 2'b00, 1'b0};
        vecs[18] = '{7'h33, 3'b000, 1'b0, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10000, 2'b00, 4'b0000, 2'b00, 1'b0};
        vecs[19] = '{7'h13, 3'b000, 1'b1, 32'h00, 3'b000, 1'b0, 3'b000, 1'b0, 5'b10100, 2'b00, 4'b0000, 2'b00, 1'b0};

        {bp_if.StallD, bp_if.StallE, bp_if.StallW} = 3'b000;
        {bp_if.FlushD, bp_if.FlushE, bp_if.FlushW} = 3'b000;
        {bp_if.Z, bp_if.N, bp_if.C} = 3'b000;
        set_f(7'h63, 3'b000, 1'b0, 32'h0);

        // Reset: everything is a bubble and every counter is weakly not-taken.
        reset = 1'b0;
        repeat (2) tick();
        check("rst_imm", bp_if.ImmFormatD, 3'b000);
        check("rst_illegal", bp_if.illegal_D, 1'b0);
        check("rst_e_ctl", {bp_if.RegWE_E_E, bp_if.RegWE_W_E, bp_if.OpBSrcE, bp_if.branch_E, bp_if.jump_E}, 5'b0);
        check("rst_e_path_alu", {bp_if.ExPathE, bp_if.ALUFuncE}, 6'b0);
        check("rst_pcsrc", {bp_if.PCSrcE, bp_if.mispredict_E}, 3'b0);
        check("rst_w", {bp_if.RegWE_E_W, bp_if.RegWE_W_W, bp_if.MemWriteW}, 3'b0);
        for (int i = 0; i < 16; i++) begin
            bp_if.pc_F = 32'(i * 4);
            #1;
            check($sformatf("rst_predict_idx%0d", i), bp_if.predict_taken_F, 1'b0);
        end
        set_f(7'h13, 3'b000, 1'b0, 32'h0);
        reset = 1'b1;
        tick();

        // Decode and resolution table.
        for (int i = 0; i < 20; i++) begin
            run_instr(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].pc, vecs[i].znc);
            $display("vec %0d op=%h f3=%b pred=%b imm=%b ill=%b ctl=%b path=%b alu=%b pcsrc=%b w=%b",
                     i, vecs[i].op, vecs[i].f3, cap_pred, cap_imm, cap_ill, cap_ctl, cap_path, cap_alu, cap_pcsrc, cap_w);
            check($sformatf("v%0d_pred", i), cap_pred, vecs[i].pred);
            check($sformatf("v%0d_imm", i), cap_imm, vecs[i].imm);
            check($sformatf("v%0d_illegal", i), cap_ill, vecs[i].ill);
            check($sformatf("v%0d_e_ctl", i), cap_ctl, vecs[i].ctl);
            check($sformatf("v%0d_path", i), cap_path, vecs[i].path);
            check($sformatf("v%0d_alu", i), cap_alu, vecs[i].alu);
            check($sformatf("v%0d_pcsrc", i), cap_pcsrc, vecs[i].pcsrc);
            check($sformatf("v%0d_mispredict", i), cap_misp, vecs[i].pcsrc != 2'b00);
            check($sformatf("v%0d_w", i), cap_w, {vecs[i].ctl[4], vecs[i].ctl[3], vecs[i].mw});
        end

        // BEQ at idx 0 taken three times: 01 -> 10 -> 11 -> 11.
        run_instr(7'h63, 3'b000, 1'b0, 32'h40, 3'b100);
        $display("beq1 pred=%b pcsrc=%b misp=%b", cap_pred, cap_pcsrc, cap_misp);
        check("beq1_pred", cap_pred, 1'b0);
        check("beq1_pcsrc", cap_pcsrc, 2'b01);
        check("beq1_mispredict", cap_misp, 1'b1);
        run_instr(7'h63, 3'b000, 1'b0, 32'h40, 3'b100);
        $display("beq2 pred=%b pcsrc=%b misp=%b", cap_pred, cap_pcsrc, cap_misp);
        check("beq2_pred", cap_pred, 1'b1);
        check("beq2_pcsrc", cap_pcsrc, 2'b00);
        check("beq2_mispredict", cap_misp, 1'b0);
        run_instr(7'h63, 3'b000, 1'b0, 32'h40, 3'b100);
        $display("beq3 pred=%b pcsrc=%b", cap_pred, cap_pcsrc);
        check("beq3_pred", cap_pred, 1'b1);
        check("beq3_pcsrc", cap_pcsrc, 2'b00);

        // Predicted-taken BNE falls through: 11 -> 10, still predicting taken.
        run_instr(7'h63, 3'b001, 1'b0, 32'h40, 3'b100);
        $display("bne pred=%b pcsrc=%b misp=%b", cap_pred, cap_pcsrc, cap_misp);
        check("bne_pred", cap_pred, 1'b1);
        check("bne_pcsrc", cap_pcsrc, 2'b10);
        check("bne_mispredict", cap_misp, 1'b1);
        set_f(7'h63, 3'b000, 1'b0, 32'h40);
        #1;
        $display("after bne predict=%b", bp_if.predict_taken_F);
        check("bne_after_predict", bp_if.predict_taken_F, 1'b1);
        set_f(7'h13, 3'b000, 1'b0, 32'h0);

        // Same-cycle update (pc 0x0C) and lookup (pc 0x4C) on idx 3.
        set_f(7'h63, 3'b000, 1'b0, 32'h0C);
        tick();
        set_f(7'h13, 3'b000, 1'b0, 32'h0);
        tick();
        set_f(7'h63, 3'b000, 1'b0, 32'h4C);
        bp_if.Z = 1'b1;
        #1;
        $display("alias pcsrc=%b predict_same_cycle=%b", bp_if.PCSrcE, bp_if.predict_taken_F);
        check("alias_pcsrc", bp_if.PCSrcE, 2'b01);
        check("alias_predict_old", bp_if.predict_taken_F, 1'b0);
        tick();
        bp_if.Z = 1'b0;
        $display("alias predict_next=%b immD=%b", bp_if.predict_taken_F, bp_if.ImmFormatD);
        check("alias_predict_new", bp_if.predict_taken_F, 1'b1);
        check("alias_imm_d", bp_if.ImmFormatD, 3'b010);
        bp_if.FlushD = 1'b1;
        set_f(7'h13, 3'b000, 1'b0, 32'h0);
        tick();
        bp_if.FlushD = 1'b0;
        $display("flushD immD=%b illegal=%b", bp_if.ImmFormatD, bp_if.illegal_D);
        check("flushd_imm", bp_if.ImmFormatD, 3'b000);
        check("flushd_illegal", bp_if.illegal_D, 1'b0);
        tick();
        $display("flushD bubble branch_E=%b pcsrc=%b", bp_if.branch_E, bp_if.PCSrcE);
        check("flushd_bubble_branch", bp_if.branch_E, 1'b0);

        // Stall a taken BEQ (idx 9) in E: no training while held, one update when released.
        set_f(7'h63, 3'b000, 1'b0, 32'h24);
        tick();
        set_f(7'h13, 3'b000, 1'b0, 32'h0);
        tick();
        bp_if.Z = 1'b1;
        #1;
        check("stall_pre_pcsrc", bp_if.PCSrcE, 2'b01);
        bp_if.StallD = 1'b1;
        bp_if.StallE = 1'b1;
        set_f(7'h63, 3'b000, 1'b0, 32'h64);
        tick();
        $display("stall branch_E=%b alu=%b pcsrc=%b predict=%b",
                 bp_if.branch_E, bp_if.ALUFuncE, bp_if.PCSrcE, bp_if.predict_taken_F);
        check("stall_hold_branch", bp_if.branch_E, 1'b1);
        check("stall_hold_alu", bp_if.ALUFuncE, 4'b0001);
        check("stall_hold_pcsrc", bp_if.PCSrcE, 2'b01);
        check("stall_no_update", bp_if.predict_taken_F, 1'b0);
        bp_if.StallD = 1'b0;
        bp_if.StallE = 1'b0;
        bp_if.FlushD = 1'b1;
        bp_if.FlushE = 1'b1;
        tick();
        bp_if.FlushD = 1'b0;
        bp_if.FlushE = 1'b0;
        bp_if.Z = 1'b0;
        #1;
        $display("flushE branch_E=%b alu=%b pcsrc=%b misp=%b predict=%b",
                 bp_if.branch_E, bp_if.ALUFuncE, bp_if.PCSrcE, bp_if.mispredict_E, bp_if.predict_taken_F);
        check("flushe_branch", bp_if.branch_E, 1'b0);
        check("flushe_alu", bp_if.ALUFuncE, 4'b0000);
        check("flushe_pcsrc", {bp_if.PCSrcE, bp_if.mispredict_E}, 3'b000);
        check("flushe_e_ctl", {bp_if.RegWE_E_E, bp_if.RegWE_W_E, bp_if.OpBSrcE, bp_if.jump_E}, 4'b0000);
        check("release_update", bp_if.predict_taken_F, 1'b1);
        set_f(7'h13, 3'b000, 1'b0, 32'h0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
